// File: rtl/dbg_pkg.sv
// dbg_pkg: shared constants, snapshot field widths and FSM state type for the debug frame transmitter
package dbg_pkg;
  localparam logic [7:0] DBG_HDR_BYTE = 8'hA5;
  localparam int DBG_CNT_W = 9;
  localparam int DBG_PC_W = 7;
  localparam int DBG_INSTR_W = 32;
  localparam int DBG_IF_ID_W = 39;
  localparam int DBG_ID_EX_W = 127;
  localparam int DBG_EX_M_W = 72;
  localparam int DBG_M_WB_W = 71;
  localparam int DBG_REGS_W = 1024;
  localparam int DBG_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
endpackage

// File: rtl/dbg_frame_tx_if.sv
// dbg_frame_tx_if: byte handshake to uart_tx (tx_start/tx_bus from master, tx_done_tick from slave)
interface dbg_frame_tx_if;
  logic tx_start;
  logic [7:0] tx_bus;
  logic tx_done_tick;
  modport master(output tx_start, tx_bus, input tx_done_tick);
  modport slave(input tx_start, tx_bus, output tx_done_tick);
endinterface

// File: rtl/dbg_frame_shreg.sv
// dbg_frame_shreg: loadable right-shift register; ports clk, rst, load, shift, d[W-1:0] in; q[7:0] = low byte out
module dbg_frame_shreg #(
  parameter int W = 1408
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic [7:0]   q
);
  logic [W-1:0] r;
  always_ff @(posedge clk) begin
    if (rst) r <= '0;
    else if (load) r <= d;
    else if (shift) r <= r >> 8;
  end
  assign q = r[7:0];
endmodule

// File: rtl/dbg_frame_tx.sv
// dbg_frame_tx: serialises a snapshot as HDR, length, payload (LSB byte first) and, with DBG_FRAME_CHECKSUM_EN, an XOR checksum byte
// ports: clk, rst, start, frame in; tx (dbg_frame_tx_if.master: tx_start, tx_bus out, tx_done_tick in); busy, done out
module dbg_frame_tx
  import dbg_pkg::*;
#(
  parameter int         FRAME_BYTES = 176,
  parameter logic [7:0] HDR_BYTE    = DBG_HDR_BYTE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [FRAME_BYTES*8-1:0] frame,
  dbg_frame_tx_if.master           tx,
  output logic                     busy,
  output logic                     done
);
  localparam logic [7:0] LEN = 8'(FRAME_BYTES);
  localparam logic [DBG_CNT_W-1:0] PAY_END = DBG_CNT_W'(FRAME_BYTES + 1);
`ifdef DBG_FRAME_CHECKSUM_EN
  localparam logic [DBG_CNT_W-1:0] LAST = DBG_CNT_W'(FRAME_BYTES + 2);
`else
  localparam logic [DBG_CNT_W-1:0] LAST = PAY_END;
`endif
  state_t state, state_n;
  logic [DBG_CNT_W-1:0] cnt;
  logic [7:0] q, cur;
  logic load, shift, fin;
  assign load = state == IDLE && start;
  assign shift = state == ISSUE && cnt >= DBG_CNT_W'(2) && cnt <= PAY_END;
  assign fin = state == WAIT && tx.tx_done_tick;
  dbg_frame_shreg #(.W(FRAME_BYTES*8)) u_shreg (
    .clk(clk), .rst(rst), .load(load), .shift(shift), .d(frame), .q(q)
  );
`ifdef DBG_FRAME_CHECKSUM_EN
  logic [7:0] ck;
  assign cur = cnt == '0 ? HDR_BYTE : cnt == DBG_CNT_W'(1) ? LEN : cnt == LAST ? ck : q;
  // covers the length byte and every payload byte, not the header
  always_ff @(posedge clk) begin
    if (rst || load) ck <= '0;
    else if (state == ISSUE && cnt != '0 && cnt <= PAY_END) ck <= ck ^ cur;
  end
`else
  assign cur = cnt == '0 ? HDR_BYTE : cnt == DBG_CNT_W'(1) ? LEN : q;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = start ? ISSUE : IDLE;
      ISSUE: state_n = WAIT;
      WAIT:  state_n = tx.tx_done_tick ? (cnt == LAST ? DONE : ISSUE) : WAIT;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      tx.tx_start <= 1'b0;
      tx.tx_bus <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= load ? '0 : fin && cnt != LAST ? cnt + DBG_CNT_W'(1) : cnt;
      tx.tx_start <= state == ISSUE;
      tx.tx_bus <= state == ISSUE ? cur : tx.tx_bus;
      busy <= state_n != IDLE;
      done <= fin && cnt == LAST;
    end
  end
endmodule

// File: tb/tb_dbg_frame_tx.sv
// tb_dbg_frame_tx: table-driven and randomized frame checks against a byte-list reference model
module tb_dbg_frame_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic st4 = 1'b0, st255 = 1'b0;
  logic [31:0] fr4 = '0;
  logic [2039:0] fr255 = '0;
  logic bz4, dn4, bz255, dn255;
  logic ta[2] = '{1'b0, 1'b0};
  logic ti[2] = '{1'b0, 1'b0};
  logic tf[2] = '{1'b0, 1'b0};
  dbg_frame_tx_if if4();
  dbg_frame_tx_if if255();
  assign if4.tx_done_tick = ta[0] | ti[0] | tf[0];
  assign if255.tx_done_tick = ta[1] | ti[1] | tf[1];
  dbg_frame_tx #(.FRAME_BYTES(4)) u4 (
    .clk(clk), .rst(rst), .start(st4), .frame(fr4), .tx(if4.master), .busy(bz4), .done(dn4)
  );
  dbg_frame_tx #(.FRAME_BYTES(255)) u255 (
    .clk(clk), .rst(rst), .start(st255), .frame(fr255), .tx(if255.master), .busy(bz255), .done(dn255)
  );
  logic txs[2], bz[2], dn[2];
  logic [7:0] txb[2];
  assign txs[0] = if4.tx_start;
  assign txs[1] = if255.tx_start;
  assign txb[0] = if4.tx_bus;
  assign txb[1] = if255.tx_bus;
  assign bz[0] = bz4;
  assign bz[1] = bz255;
  assign dn[0] = dn4;
  assign dn[1] = dn255;

  int vecs = 0, errs = 0, dones = 0;
  logic [7:0] cap[$];
  logic [7:0] last_b = '0;
  bit spur_en = 1'b0;
  int cd[2] = '{0, 0};
  int g[2] = '{0, 0};
  bit armed[2] = '{1'b0, 1'b0};

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [31:0] frame;
    logic [7:0]  ck;
    bit          mid;
    bit          spur;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  function automatic bq_t model(input int n, input logic [2039:0] f);
    bq_t r;
    logic [7:0] x;
    r.push_back(8'hA5);
    r.push_back(8'(n));
    x = 8'(n);
    for (int i = 0; i < n; i++) begin
      r.push_back(f[8*i +: 8]);
      x ^= f[8*i +: 8];
    end
`ifdef DBG_FRAME_CHECKSUM_EN
    r.push_back(x);
`endif
    return r;
  endfunction

  // uart_tx stand-in: capture each byte, tick 10 cycles later, optionally echo a stray tick into ISSUE
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (armed[i]) g[i]++;
        ti[i] = spur_en && ta[i];
        ta[i] = 1'b0;
        if (rst) begin
          cd[i] = 0;
          armed[i] = 1'b0;
        end else if (cd[i] > 0) begin
          cd[i]--;
          if (cd[i] == 0) begin
            ta[i] = 1'b1;
            g[i] = 0;
            armed[i] = 1'b1;
            chk("tx_bus_hold", 32'(txb[i]), 32'(last_b));
          end
        end
        if (txs[i]) begin
          if (armed[i]) begin
            chk("tick_to_start", g[i], 2);
            armed[i] = 1'b0;
          end
          cap.push_back(txb[i]);
          last_b = txb[i];
          cd[i] = 10;
        end
        if (dn[i]) begin
          dones++;
          armed[i] = 1'b0;
        end
      end
    end
  end

  task automatic send(input int s, input logic [2039:0] f, input bit mid, input bit spur,
                      input bit use_tail, input logic [7:0] tail);
    bq_t exp;
    int n, k;
    n = s == 0 ? 4 : 255;
    exp = model(n, f);
    cap.delete();
    dones = 0;
    spur_en = spur;
    @(negedge clk);
    if (s == 0) begin fr4 = f[31:0]; st4 = 1'b1; end
    else begin fr255 = f; st255 = 1'b1; end
    @(negedge clk);
    st4 = 1'b0;
    st255 = 1'b0;
    chk("busy_rise", 32'(bz[s]), 1);
    chk("no_early_start", 32'(txs[s]), 0);
    @(negedge clk);
    chk("hdr_latency", 32'(txs[s]), 1);
    chk("hdr_byte", 32'(txb[s]), 32'hA5);
    if (mid) begin
      k = 0;
      while (cap.size() < 3 && k < 500) begin @(negedge clk); k++; end
      fr4 = 32'hDEADBEEF;
      st4 = 1'b1;
      @(negedge clk);
      st4 = 1'b0;
    end
    k = 0;
    while (!dn[s] && k < 6000) begin @(negedge clk); k++; end
    chk("done_seen", 32'(dn[s]), 1);
    chk("busy_at_done", 32'(bz[s]), 1);
    @(negedge clk);
    chk("busy_fall", 32'(bz[s]), 0);
    chk("done_pulse", 32'(dn[s]), 0);
    repeat (20) @(negedge clk);
    chk("done_count", dones, 1);
    chk("byte_count", cap.size(), exp.size());
    for (int i = 0; i < exp.size() && i < cap.size(); i++) chk("byte", 32'(cap[i]), 32'(exp[i]));
    if (use_tail && cap.size() > 0) chk("tail_byte", 32'(cap[cap.size()-1]), 32'(tail));
    spur_en = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    tbl = '{
      '{32'h44332211, 8'h40, 1'b0, 1'b0},
      '{32'h44332211, 8'h40, 1'b1, 1'b0},
      '{32'h44332211, 8'h40, 1'b0, 1'b1},
      '{32'h00000000, 8'h04, 1'b0, 1'b0},
      '{32'hFFFFFFFF, 8'h04, 1'b0, 1'b0},
      '{32'h80402010, 8'hF4, 1'b0, 1'b1},
      '{32'h010000A5, 8'hA0, 1'b1, 1'b1}
    };
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_tx_start", 32'(txs[i]), 0);
      chk("rst_tx_bus", 32'(txb[i]), 0);
      chk("rst_busy", 32'(bz[i]), 0);
      chk("rst_done", 32'(dn[i]), 0);
    end
    rst = 1'b0;
    cap.delete();
    @(negedge clk);
    tf[0] = 1'b1;
    repeat (3) @(negedge clk);
    tf[0] = 1'b0;
    @(negedge clk);
    chk("idle_tick_busy", 32'(bz[0]), 0);
    chk("idle_tick_no_tx", cap.size(), 0);
    for (int i = 0; i < 7; i++) begin
`ifdef DBG_FRAME_CHECKSUM_EN
      send(0, {2008'b0, tbl[i].frame}, tbl[i].mid, tbl[i].spur, 1'b1, tbl[i].ck);
`else
      send(0, {2008'b0, tbl[i].frame}, tbl[i].mid, tbl[i].spur, 1'b1, tbl[i].frame[31:24]);
`endif
    end
    for (int i = 0; i < 6; i++)
      send(0, {2008'b0, 32'($urandom)}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 8'h00);
    cap.delete();
    @(negedge clk);
    fr4 = 32'h44332211;
    st4 = 1'b1;
    @(negedge clk);
    st4 = 1'b0;
    k = 0;
    while (cap.size() < 3 && k < 500) begin @(negedge clk); k++; end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx_start", 32'(txs[0]), 0);
    chk("midrst_busy", 32'(bz[0]), 0);
    chk("midrst_tx_bus", 32'(txb[0]), 0);
    chk("midrst_done", 32'(dn[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("midrst_abandoned", cap.size(), 3);
    send(0, {2008'b0, 32'h44332211}, 1'b0, 1'b0, 1'b0, 8'h00);
    send(1, '1, 1'b0, 1'b0, 1'b0, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
